packet_switch_igr_wrr_sched: RTL

- Packet-granular weighted round-robin scheduler for the ingress packet switch.
- Shares one egress datapath between N input queues. Each queue presents a "packet at head" request.
- Grants one port at a time and holds that grant from the start-of-packet handshake to end-of-packet.
- Each port may send up to weight[i] consecutive packets before the grant rotates; optional strict priority for port 0.

---
 rtl/packet_switch_igr_wrr_sched_if.sv | 27 ++
 rtl/packet_switch_igr_wrr_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/packet_switch_igr_wrr_sched_if.sv
// Request/grant bundle between the ingress queues and the WRR packet scheduler.
// The queue side is the master; the scheduler is the slave.
interface packet_switch_igr_wrr_sched_if #(
  parameter int N         = 4,
  parameter int WGT_WIDTH = 4,
  parameter int N_WIDTH   = (N < 2) ? 1 : $clog2(N)
);
  logic [N-1:0]           req;
  logic [N*WGT_WIDTH-1:0] weight;
  logic                   gnt_rdy;
  logic                   eop_done;
  logic                   gnt_vld;
  logic [N_WIDTH-1:0]     gnt;
  logic                   busy;
  logic [WGT_WIDTH-1:0]   credit;
  logic                   proto_err;

  modport master (
    output req, weight, gnt_rdy, eop_done,
    input  gnt_vld, gnt, busy, credit, proto_err
  );

  modport slave (
    input  req, weight, gnt_rdy, eop_done,
    output gnt_vld, gnt, busy, credit, proto_err
  );
endinterface

// File: rtl/packet_switch_igr_wrr_sched.sv
// Packet-granular weighted round-robin scheduler: one grant held from SOP
// accept to EOP, up to weight[i] back-to-back packets per turn, optional port-0 priority.
module packet_switch_igr_wrr_sched #(
  parameter int N         = 4,
  parameter int WGT_WIDTH = 4,
  parameter int SP_IF0    = 0,
  parameter int N_WIDTH   = (N < 2) ? 1 : $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  packet_switch_igr_wrr_sched_if.slave bus
);

  localparam int unsigned NU = N;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t               state_q, state_d;
  logic                 gnt_vld_q, gnt_vld_d;
  logic [N_WIDTH-1:0]   gnt_q, gnt_d;
  logic [N_WIDTH-1:0]   rr_q, rr_d;
  logic                 busy_q, busy_d;
  logic [WGT_WIDTH-1:0] credit_q, credit_d;
  logic                 perr_q, perr_d;

  logic [WGT_WIDTH-1:0] wgt [N];
  logic [N_WIDTH-1:0]   rr_sel;
  logic [N_WIDTH-1:0]   idx_n;
  logic [N_WIDTH-1:0]   sel;
  logic                 rr_found;
  logic                 sp_hit;
  logic                 any_req;
  logic                 accept;
  logic                 decide;
  logic                 stay;
  logic                 cont_same;
  logic [WGT_WIDTH-1:0] reload;
  logic [WGT_WIDTH-1:0] credit_dec;
  logic [WGT_WIDTH-1:0] credit_ref;

  always_comb begin
    for (int unsigned i = 0; i < NU; i++) begin
      wgt[i] = bus.weight[i*WGT_WIDTH +: WGT_WIDTH];
    end
  end

  // Circular search starting just after the last rotated-to port.
  always_comb begin
    rr_sel   = rr_q;
    rr_found = 1'b0;
    idx_n    = '0;
    for (int unsigned i = 1; i <= NU; i++) begin
      idx_n = N_WIDTH'((32'(rr_q) + i) % NU);
      if (!rr_found && bus.req[idx_n]) begin
        rr_sel   = idx_n;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    sp_hit     = (SP_IF0 != 0) && bus.req[0];
    sel        = sp_hit ? '0 : rr_sel;
    any_req    = |bus.req;
    reload     = (wgt[sel] == '0) ? WGT_WIDTH'(1) : wgt[sel];
    accept     = (state_q == GRANT) && bus.gnt_rdy;
    credit_dec = (credit_q == '0) ? '0 : credit_q - WGT_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    gnt_vld_d  = gnt_vld_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    busy_d     = busy_q;
    credit_d   = credit_q;
    perr_d     = perr_q;
    decide     = 1'b0;
    credit_ref = credit_q;
    stay       = 1'b0;
    cont_same  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.eop_done) perr_d = 1'b1;
        if (any_req) begin
          // Leftover credit only belongs to sel if sel was also the last grant.
          cont_same = !sp_hit && (sel == rr_q) && (gnt_q == rr_q) && (credit_q != '0);
          gnt_d     = sel;
          gnt_vld_d = 1'b1;
          state_d   = GRANT;
          if (!cont_same) credit_d = reload;
          if (!sp_hit)    rr_d     = sel;
        end
      end
      GRANT: begin
        if (accept) begin
          gnt_vld_d = 1'b0;
          credit_d  = credit_dec;
          if (bus.eop_done) begin
            decide     = 1'b1;
            credit_ref = credit_dec;
          end else begin
            busy_d  = 1'b1;
            state_d = XFER;
          end
        end else if (bus.eop_done) begin
          perr_d = 1'b1;
        end
      end
      XFER: begin
        if (bus.eop_done) decide = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // End-of-packet decision, shared by XFER and the single-beat accept.
    if (decide) begin
      busy_d = 1'b0;
      stay   = bus.req[gnt_q] && (credit_ref != '0) && !(sp_hit && (gnt_q != '0));
      if (stay) begin
        gnt_vld_d = 1'b1;
        state_d   = GRANT;
      end else if (any_req) begin
        gnt_d     = sel;
        credit_d  = reload;
        gnt_vld_d = 1'b1;
        state_d   = GRANT;
        if (!sp_hit) rr_d = sel;
      end else begin
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_vld_q <= 1'b0;
      gnt_q     <= '0;
      rr_q      <= N_WIDTH'(N - 1);
      busy_q    <= 1'b0;
      credit_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      credit_q  <= credit_d;
      perr_q    <= perr_d;
    end
  end

  assign bus.gnt_vld   = gnt_vld_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.credit    = credit_q;
  assign bus.proto_err = perr_q;

endmodule
